// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the MEM-stage data port. It accepts a load or
//   store request and holds the pipeline with stallreq for LATENCY cycles.
//   It then commits the byte-lane write or returns the addressed word, and
//   spends one DONE cycle with stallreq low so the pipeline can advance.
//
// Parameters
//   ADDR_WIDTH : word-address bits; capacity 2**ADDR_WIDTH 32-bit words
//   LATENCY    : stall cycles per access, 1..15
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   ce       : request valid from MEM stage
//   we       : 1 = store, 0 = load
//   addr     : byte address; bits [1:0] ignored, lanes come from sel
//   sel      : byte lanes, big-endian (sel[3] = data[31:24] = offset 0)
//   data_i   : store data (already byte-replicated for sb/sh)
//   data_o   : load data, full word; holds until the next load commit
//   stallreq : hold pipeline while an access is in flight
//   err      : one-cycle pulse in DONE for an out-of-range access
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq,
  output logic        err
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  // With a single wait cycle the acceptance edge is also the commit edge.
  localparam bit          SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;

  // Request captured at acceptance; MEM keeps its outputs stable anyway,
  // but the commit must not depend on that.
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_data;

  logic [31:0] mem [DEPTH];

  // Commit-side view of the request.
  logic                  take_direct;
  logic                  commit;
  logic                  c_we;
  logic [31:0]           c_addr;
  logic [3:0]            c_sel;
  logic [31:0]           c_data;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic                  c_oor;

  // Next state and stall request.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    unique case (state)
      IDLE: begin
        stallreq = ce;
        if (ce) state_next = SINGLE ? DONE : WAIT;
      end
      WAIT: begin
        stallreq = 1'b1;
        if (cnt == 4'd1) state_next = DONE;
      end
      DONE: begin
        // The ce seen here is the request just served; never re-accept it.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) stallreq = 1'b0;
  end

  // Commit source: live inputs on the acceptance edge when LATENCY is 1,
  // otherwise the captured copy on the last WAIT edge.
  always_comb begin
    take_direct = SINGLE && (state == IDLE) && ce;
    commit      = take_direct || ((state == WAIT) && (cnt == 4'd1));
    c_we        = take_direct ? we     : req_we;
    c_addr      = take_direct ? addr   : req_addr;
    c_sel       = take_direct ? sel    : req_sel;
    c_data      = take_direct ? data_i : req_data;
    c_idx       = c_addr[ADDR_WIDTH+1:2];
    c_oor       = (c_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  end

  // Control state, capture registers and load data.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      data_o   <= 32'd0;
      err      <= 1'b0;
      req_we   <= 1'b0;
      req_addr <= 32'd0;
      req_sel  <= 4'd0;
      req_data <= 32'd0;
    end else begin
      state <= state_next;
      err   <= commit && c_oor;

      if ((state == IDLE) && ce) begin
        req_we   <= we;
        req_addr <= addr;
        req_sel  <= sel;
        req_data <= data_i;
        cnt      <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (commit && !c_we) begin
        data_o <= c_oor ? 32'd0 : mem[c_idx];
      end
    end
  end

  // Storage array with per-byte write enables. A reset arriving on the
  // commit edge drops the write.
  // NOTE: the array is deliberately left out of reset so it maps onto RAM;
  // its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. It drives three instances
// that share address/data inputs and have separate chip enables:
//   index 0 : LATENCY=2, index 1 : LATENCY=4, index 2 : LATENCY=1
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ce_v = 3'b000;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] data_i = 32'd0;

  logic [2:0]  stall_v;
  logic [2:0]  err_v;
  logic [31:0] dout0, dout1, dout2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .ce(ce_v[0]), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(dout0), .stallreq(stall_v[0]), .err(err_v[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .ce(ce_v[1]), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(dout1), .stallreq(stall_v[1]), .err(err_v[1])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .ce(ce_v[2]), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(dout2), .stallreq(stall_v[2]), .err(err_v[2])
  );

  function automatic logic [31:0] get_dout(input int k);
    case (k)
      0:       return dout0;
      1:       return dout1;
      default: return dout2;
    endcase
  endfunction

  // Present one request to instance k and follow it to its DONE cycle.
  // Returns the number of cycles stallreq was high, and data_o/err as seen
  // in DONE. ce is left high, so a following call runs back-to-back.
  task automatic access(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output int stalls, output logic [31:0] dout,
                        output logic e);
    @(negedge clk);
    we = w; addr = a; sel = s; data_i = d;
    ce_v[k] = 1'b1;
    #1;
    stalls = 0;
    while (stall_v[k] === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    dout = get_dout(k);
    e    = err_v[k];
  endtask

  // Drop every chip enable during the IDLE cycle after a DONE.
  task automatic release_ce();
    @(negedge clk);
    ce_v = 3'b000;
    #1;
  endtask

  int          st;
  logic [31:0] dv;
  logic        ev;

  task automatic test_reset();
    rst = 1'b1; ce_v = 3'b111;
    we = 1'b1; addr = 32'h40; sel = 4'hF; data_i = 32'h1122_3344;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (stall_v !== 3'b000) begin
        errors++; $display("FAIL reset_stall cyc%0d: got %b want 000", c, stall_v);
      end
      checks++;
      if (err_v !== 3'b000) begin
        errors++; $display("FAIL reset_err cyc%0d: got %b want 000", c, err_v);
      end
      checks++;
      if (dout0 !== 32'd0 || dout1 !== 32'd0 || dout2 !== 32'd0) begin
        errors++; $display("FAIL reset_data cyc%0d: got %h %h %h want 0", c, dout0, dout1, dout2);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (stall_v !== 3'b111) begin
      errors++; $display("FAIL post_reset_stall: got %b want 111", stall_v);
    end
    // All three accept the store; ce drops mid-access and it still commits.
    @(negedge clk);
    ce_v = 3'b000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_word_rw();
    access(0, 1'b1, 32'h40, 4'hF, 32'h1122_3344, st, dv, ev);
    checks++;
    if (st !== 2) begin errors++; $display("FAIL sw40_stalls: got %0d want 2", st); end
    checks++;
    if (ev !== 1'b0) begin errors++; $display("FAIL sw40_err: got %b want 0", ev); end
    access(0, 1'b0, 32'h40, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (st !== 2) begin errors++; $display("FAIL lw40_stalls: got %0d want 2", st); end
    checks++;
    if (dv !== 32'h1122_3344) begin errors++; $display("FAIL lw40_data: got %h want 11223344", dv); end
    release_ce();
    // The store issued during reset release committed despite ce dropping.
    access(1, 1'b0, 32'h40, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (st !== 4) begin errors++; $display("FAIL lat4_lw40_stalls: got %0d want 4", st); end
    checks++;
    if (dv !== 32'h1122_3344) begin errors++; $display("FAIL lat4_lw40_data: got %h want 11223344", dv); end
    release_ce();
  endtask

  task automatic test_byte_lanes();
    access(0, 1'b1, 32'h41, 4'b0100, 32'hAAAA_AAAA, st, dv, ev);
    checks++;
    if (st !== 2) begin errors++; $display("FAIL sb41_stalls: got %0d want 2", st); end
    access(0, 1'b0, 32'h40, 4'b0100, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'h11AA_3344) begin errors++; $display("FAIL sb41_merge: got %h want 11aa3344", dv); end
    access(0, 1'b1, 32'h40, 4'b0000, 32'hFFFF_FFFF, st, dv, ev);
    checks++;
    if (st !== 2) begin errors++; $display("FAIL sel0_store_stalls: got %0d want 2", st); end
    access(0, 1'b0, 32'h40, 4'b0000, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'h11AA_3344) begin errors++; $display("FAIL sel0_nochange: got %h want 11aa3344", dv); end
    access(0, 1'b1, 32'h40, 4'b1001, 32'h5566_7788, st, dv, ev);
    access(0, 1'b0, 32'h40, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'h55AA_3388) begin errors++; $display("FAIL sel1001_merge: got %h want 55aa3388", dv); end
    release_ce();
  endtask

  task automatic test_out_of_range();
    access(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, st, dv, ev);
    access(0, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, st, dv, ev);
    checks++;
    if (ev !== 1'b1) begin errors++; $display("FAIL oor_sw_err: got %b want 1", ev); end
    release_ce();
    checks++;
    if (err_v[0] !== 1'b0) begin errors++; $display("FAIL oor_sw_err_pulse: got %b want 0", err_v[0]); end
    access(0, 1'b1, 32'h8000_0040, 4'hF, 32'h0BAD_0BAD, st, dv, ev);
    checks++;
    if (ev !== 1'b1) begin errors++; $display("FAIL oor_high_err: got %b want 1", ev); end
    access(0, 1'b0, 32'h0, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_word0_kept: got %h want cafef00d", dv); end
    checks++;
    if (ev !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b want 0", ev); end
    access(0, 1'b0, 32'h1000, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'd0) begin errors++; $display("FAIL oor_lw_data: got %h want 0", dv); end
    checks++;
    if (ev !== 1'b1) begin errors++; $display("FAIL oor_lw_err: got %b want 1", ev); end
    access(0, 1'b0, 32'h40, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'h55AA_3388) begin errors++; $display("FAIL oor_high_kept: got %h want 55aa3388", dv); end
    // Last implemented word.
    access(0, 1'b1, 32'hFFC, 4'hF, 32'h0BAD_C0DE, st, dv, ev);
    access(0, 1'b0, 32'hFFC, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'h0BAD_C0DE || ev !== 1'b0) begin
      errors++; $display("FAIL top_word: got %h err %b want 0badc0de err 0", dv, ev);
    end
    release_ce();
    checks++;
    if (err_v[0] !== 1'b0) begin errors++; $display("FAIL err_idle: got %b want 0", err_v[0]); end
  endtask

  task automatic test_reset_mid_access();
    access(1, 1'b1, 32'h80, 4'hF, 32'h0102_0304, st, dv, ev);
    checks++;
    if (st !== 4) begin errors++; $display("FAIL lat4_sw_stalls: got %0d want 4", st); end
    release_ce();
    @(negedge clk);                       // cycle 1: acceptance
    we = 1'b1; addr = 32'h80; sel = 4'hF; data_i = 32'hDEAD_BEEF;
    ce_v[1] = 1'b1;
    @(negedge clk);                       // cycle 2: WAIT
    @(negedge clk);                       // cycle 3: reset sampled at its end
    rst = 1'b1;
    #1;
    checks++;
    if (stall_v[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", stall_v[1]); end
    @(negedge clk);
    rst = 1'b0; ce_v = 3'b000;
    #1;
    checks++;
    if (stall_v[1] !== 1'b0 || dout1 !== 32'd0) begin
      errors++; $display("FAIL rst_mid_idle: stall %b data %h want 0 0", stall_v[1], dout1);
    end
    repeat (4) @(negedge clk);
    access(1, 1'b0, 32'h80, 4'hF, 32'd0, st, dv, ev);
    checks++;
    if (dv !== 32'h0102_0304) begin errors++; $display("FAIL rst_mid_dropped: got %h want 01020304", dv); end
    release_ce();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    int          order [4];
    time         t_prev;
    vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0001;
    vals[2] = 32'h3333_0002; vals[3] = 32'h4444_0003;
    order[0] = 3; order[1] = 0; order[2] = 2; order[3] = 1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      access(2, 1'b1, 32'h100 + 32'(4*i), 4'hF, vals[i], st, dv, ev);
      checks++;
      if (st !== 1) begin errors++; $display("FAIL b2b_sw%0d_stalls: got %0d want 1", i, st); end
      if (i > 0) begin
        checks++;
        if ($time - t_prev !== 20) begin
          errors++; $display("FAIL b2b_sw%0d_spacing: got %0t want 20", i, $time - t_prev);
        end
      end
      t_prev = $time;
    end
    for (int i = 0; i < 4; i++) begin
      access(2, 1'b0, 32'h100 + 32'(4*order[i]), 4'hF, 32'd0, st, dv, ev);
      checks++;
      if (st !== 1) begin errors++; $display("FAIL b2b_lw%0d_stalls: got %0d want 1", i, st); end
      checks++;
      if (dv !== vals[order[i]]) begin
        errors++; $display("FAIL b2b_lw%0d_data: got %h want %h", i, dv, vals[order[i]]);
      end
      checks++;
      if ($time - t_prev !== 20) begin
        errors++; $display("FAIL b2b_lw%0d_spacing: got %0t want 20", i, $time - t_prev);
      end
      t_prev = $time;
    end
    release_ce();
    checks++;
    if (stall_v[2] !== 1'b0) begin errors++; $display("FAIL b2b_idle_stall: got %b want 0", stall_v[2]); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_out_of_range();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
